// File: rtl/alu_pkg.sv
// alu_pkg: ctl encodings, mul/div FSM state type and decode helper shared by alu_mc and alu_mdu.
package alu_pkg;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SLL   = 4'b0011;
  localparam logic [3:0] ALU_SRL   = 4'b0100;
  localparam logic [3:0] ALU_SRA   = 4'b0101;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_SLT   = 4'b0111;
  localparam logic [3:0] ALU_SLTU  = 4'b1000;
  localparam logic [3:0] ALU_MULTU = 4'b1001;
  localparam logic [3:0] ALU_MULT  = 4'b1010;
  localparam logic [3:0] ALU_DIVU  = 4'b1011;
  localparam logic [3:0] ALU_NOR   = 4'b1100;
  localparam logic [3:0] ALU_XOR   = 4'b1101;
  localparam logic [3:0] ALU_DIV   = 4'b1110;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    FIX
  } alu_state_e;

  function automatic logic is_muldiv(input logic [3:0] ctl);
    return (ctl == ALU_MULTU) || (ctl == ALU_MULT) ||
           (ctl == ALU_DIVU)  || (ctl == ALU_DIV);
  endfunction

endpackage

// File: rtl/alu_mdu.sv
// alu_mdu: iterative shift-add multiplier / restoring divider with HI/LO registers.
// Only built when ALU_MULDIV_EN is defined; operates on magnitudes, signs applied in fix-up.
`ifdef ALU_MULDIV_EN
module alu_mdu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             mul_step_i,
  input  logic             div_step_i,
  input  logic             fix_i,
  input  logic [3:0]       ctl_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [WIDTH-1:0]   acc_q, qr_q, m_q, a_q, hi_q, lo_q;
  logic               div_q, negq_q, negr_q, dz_q;
  logic               sgn, a_neg, b_neg, r_ge;
  logic [WIDTH-1:0]   a_mag, b_mag, rdiff, quo_fix, rem_fix;
  logic [WIDTH:0]     msum, rsh;
  logic [2*WIDTH-1:0] prod, prod_fix;

  always_comb begin
    sgn      = (ctl_i == ALU_MULT) || (ctl_i == ALU_DIV);
    a_neg    = sgn && a_i[WIDTH-1];
    b_neg    = sgn && b_i[WIDTH-1];
    a_mag    = a_neg ? -a_i : a_i;
    b_mag    = b_neg ? -b_i : b_i;
    msum     = {1'b0, acc_q} + (qr_q[0] ? {1'b0, m_q} : '0);
    // Partial remainder never exceeds 2*divisor, so the low WIDTH bits of the difference are exact.
    rsh      = {acc_q, qr_q[WIDTH-1]};
    r_ge     = rsh >= {1'b0, m_q};
    rdiff    = rsh[WIDTH-1:0] - m_q;
    prod     = {acc_q, qr_q};
    prod_fix = negq_q ? -prod : prod;
    quo_fix  = negq_q ? -qr_q : qr_q;
    rem_fix  = negr_q ? -acc_q : acc_q;
  end

  always_ff @(posedge clk) begin
    if (load_i) begin
      acc_q  <= '0;
      qr_q   <= a_mag;
      m_q    <= b_mag;
      a_q    <= a_i;
      div_q  <= (ctl_i == ALU_DIVU) || (ctl_i == ALU_DIV);
      negq_q <= a_neg ^ b_neg;
      negr_q <= a_neg;
      dz_q   <= (b_i == '0);
    end else if (mul_step_i) begin
      acc_q <= msum[WIDTH:1];
      qr_q  <= {msum[0], qr_q[WIDTH-1:1]};
    end else if (div_step_i) begin
      acc_q <= r_ge ? rdiff : rsh[WIDTH-1:0];
      qr_q  <= {qr_q[WIDTH-2:0], r_ge};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (fix_i) begin
      if (!div_q) begin
        {hi_q, lo_q} <= prod_fix;
      end else if (dz_q) begin
        hi_q <= a_q;
        lo_q <= '1;
      end else begin
        hi_q <= rem_fix;
        lo_q <= quo_fix;
      end
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule
`endif

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle EX-stage ALU with start/busy/done handshake.
// Define ALU_MULDIV_EN to build mult/multu/div/divu with HI/LO; otherwise those codes yield out=0.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       ctl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             z,
  output logic             ovf,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int SHW = $clog2(WIDTH);

  logic signed [WIDTH-1:0] a_s, b_s;
  logic        [WIDTH-1:0] sum, diff, res_d, out_q;
  logic        [SHW-1:0]   shamt;
  logic                    ovf_d, ovf_q, z_q, done_q;
  logic                    accept, simple_req, md_done;

  assign a_s    = a;
  assign b_s    = b;
  assign accept = start && !busy;

  always_comb begin
    sum   = a + b;
    diff  = a - b;
    shamt = a[SHW-1:0];
    res_d = '0;
    ovf_d = 1'b0;
    case (ctl)
      ALU_ADD: begin
        res_d = sum;
        ovf_d = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUB: begin
        res_d = diff;
        ovf_d = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_AND:  res_d = a & b;
      ALU_OR:   res_d = a | b;
      ALU_NOR:  res_d = ~(a | b);
      ALU_XOR:  res_d = a ^ b;
      ALU_SLT:  res_d = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
      ALU_SLTU: res_d = {{(WIDTH-1){1'b0}}, (a < b)};
      ALU_SLL:  res_d = b << shamt;
      ALU_SRL:  res_d = b >> shamt;
      ALU_SRA:  res_d = b_s >>> shamt;
      default:  res_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q  <= '0;
      z_q    <= 1'b1;
      ovf_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= simple_req || md_done;
      if (simple_req) begin
        out_q <= res_d;
        z_q   <= (res_d == '0);
        ovf_q <= ovf_d;
      end
    end
  end

`ifdef ALU_MULDIV_EN
  localparam logic [SHW:0] CNT_LAST = (SHW+1)'(WIDTH - 1);

  alu_state_e     state_q, state_d;
  logic [SHW:0]   cnt_q, cnt_d;
  logic           md_load, md_fix;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // One load edge, WIDTH iteration edges, one fix-up edge; done is registered off the fix-up.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    md_load = 1'b0;
    md_fix  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept && is_muldiv(ctl)) begin
          md_load = 1'b1;
          cnt_d   = '0;
          state_d = ((ctl == ALU_MULT) || (ctl == ALU_MULTU)) ? MUL : DIV;
        end
      end
      MUL, DIV: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = FIX;
      end
      FIX: begin
        md_fix  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy       = (state_q != IDLE);
  assign md_done    = md_fix;
  assign simple_req = accept && !is_muldiv(ctl);

  alu_mdu #(
    .WIDTH(WIDTH)
  ) u_mdu (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (md_load),
    .mul_step_i (state_q == MUL),
    .div_step_i (state_q == DIV),
    .fix_i      (md_fix),
    .ctl_i      (ctl),
    .a_i        (a),
    .b_i        (b),
    .hi_o       (hi),
    .lo_o       (lo)
  );
`else
  assign busy       = 1'b0;
  assign hi         = '0;
  assign lo         = '0;
  assign md_done    = 1'b0;
  assign simple_req = accept;
`endif

  assign out  = out_q;
  assign z    = z_q;
  assign ovf  = ovf_q;
  assign done = done_q;

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: vector table, random model comparison and handshake corner cases for alu_mc (WIDTH=32).
module tb_alu_mc;

  localparam int W = 32;
  localparam logic [3:0] C_AND = 4'b0000, C_OR = 4'b0001, C_ADD = 4'b0010, C_SLL = 4'b0011;
  localparam logic [3:0] C_SRL = 4'b0100, C_SRA = 4'b0101, C_SUB = 4'b0110, C_SLT = 4'b0111;
  localparam logic [3:0] C_SLTU = 4'b1000, C_MULTU = 4'b1001, C_MULT = 4'b1010, C_DIVU = 4'b1011;
  localparam logic [3:0] C_NOR = 4'b1100, C_XOR = 4'b1101, C_DIV = 4'b1110;

  logic         clk = 1'b0;
  logic         rst_n, start;
  logic [3:0]   ctl;
  logic [W-1:0] a, b;
  logic         busy, done, z, ovf;
  logic [W-1:0] out, hi, lo;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_out, exp_hi, exp_lo;
  logic         exp_z, exp_ovf;

  typedef struct {
    string        nm;
    logic [3:0]   c;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] eo;
    logic         ez;
    logic         ev;
  } vec_t;
  vec_t tbl[$];

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ctl(ctl), .a(a), .b(b),
    .busy(busy), .done(done), .out(out), .z(z), .ovf(ovf), .hi(hi), .lo(lo)
  );

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic void model_simple(input logic [3:0] c, input logic [W-1:0] x, y,
                                       output logic [W-1:0] o, output logic v);
    longint s;
    int     n;
    o = '0;
    v = 1'b0;
    n = int'(x[4:0]);
    case (c)
      C_ADD: begin
        s = longint'($signed(x)) + longint'($signed(y));
        o = 32'(s);
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      C_SUB: begin
        s = longint'($signed(x)) - longint'($signed(y));
        o = 32'(s);
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      C_AND:  o = x & y;
      C_OR:   o = x | y;
      C_NOR:  o = ~(x | y);
      C_XOR:  o = x ^ y;
      C_SLT:  o = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      C_SLTU: o = (x < y) ? 32'd1 : 32'd0;
      C_SLL:  o = y << n;
      C_SRL:  o = y >> n;
      C_SRA: begin
        o = y;
        for (int i = 0; i < n; i++) o = {o[W-1], o[W-1:1]};
      end
      default: o = '0;
    endcase
  endfunction

  function automatic void model_md(input logic [3:0] c, input logic [W-1:0] x, y,
                                   output logic [W-1:0] h, output logic [W-1:0] l);
    longint          sx, sy, sq, sr;
    longint unsigned ux, uy;
    logic [63:0]     p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = 64'(x);
    uy = 64'(y);
    if (c == C_MULT)       p = 64'(sx * sy);
    else if (c == C_MULTU) p = ux * uy;
    else if (y == '0)      p = {x, 32'hFFFF_FFFF};
    else if (c == C_DIVU)  p = {32'(ux % uy), 32'(ux / uy)};
    else begin
      sq = sx / sy;
      sr = sx % sy;
      p  = {32'(sr), 32'(sq)};
    end
    h = p[63:32];
    l = p[31:0];
  endfunction

  task automatic issue(input logic [3:0] c, input logic [W-1:0] x, y);
    @(negedge clk);
    start = 1'b1;
    ctl   = c;
    a     = x;
    b     = y;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_simple(input string nm, input logic [3:0] c, input logic [W-1:0] x, y,
                            input logic [W-1:0] eo, input logic ez, input logic ev);
    issue(c, x, y);
    chk({nm, " out"}, out, eo);
    chk({nm, " z"}, z, ez);
    chk({nm, " ovf"}, ovf, ev);
    chk({nm, " done"}, done, 1);
    chk({nm, " busy"}, busy, 0);
    chk({nm, " hi"}, hi, exp_hi);
    chk({nm, " lo"}, lo, exp_lo);
    exp_out = eo;
    exp_z   = ez;
    exp_ovf = ev;
    @(posedge clk);
    #1;
    chk({nm, " done_clr"}, done, 0);
  endtask

  task automatic wait_done(output int n, output bit busy_ok);
    n = 0;
    busy_ok = 1'b1;
    while (!done && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (!done && !busy) busy_ok = 1'b0;
    end
  endtask

  task automatic run_md(input string nm, input logic [3:0] c, input logic [W-1:0] x, y,
                        input logic [W-1:0] eh, el, input bit intr);
    int n;
    bit busy_ok;
    issue(c, x, y);
    chk({nm, " busy_start"}, busy, 1);
    n = 0;
    busy_ok = 1'b1;
    while (!done && n < 100) begin
      if (intr && n == 4) begin
        start = 1'b1;
        ctl   = C_DIVU;
        a     = 32'd9;
        b     = 32'd4;
      end
      @(posedge clk);
      #1;
      n++;
      if (intr && n == 5) start = 1'b0;
      if (!done && !busy) busy_ok = 1'b0;
    end
    exp_hi = eh;
    exp_lo = el;
    chk({nm, " latency"}, n, W + 1);
    chk({nm, " busy_held"}, busy_ok, 1);
    chk({nm, " busy_done"}, busy, 0);
    chk({nm, " hi"}, hi, eh);
    chk({nm, " lo"}, lo, el);
    chk({nm, " out_kept"}, out, exp_out);
    chk({nm, " z_kept"}, z, exp_z);
    chk({nm, " ovf_kept"}, ovf, exp_ovf);
    @(posedge clk);
    #1;
    chk({nm, " done_clr"}, done, 0);
  endtask

  initial begin
    logic [3:0]   rc;
    logic [W-1:0] rx, ry, mo, mh, ml;
    logic         mv;

    rst_n = 1'b0;
    start = 1'b0;
    ctl   = '0;
    a     = '0;
    b     = '0;
    exp_out = '0; exp_z = 1'b1; exp_ovf = 1'b0; exp_hi = '0; exp_lo = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst out", out, 0);
    chk("rst z", z, 1);
    chk("rst ovf", ovf, 0);
    chk("rst hi", hi, 0);
    chk("rst lo", lo, 0);
    @(negedge clk);
    rst_n = 1'b1;

    tbl.push_back('{"add_ovf",  C_ADD,  32'h7FFF_FFFF, 32'h1,          32'h8000_0000, 1'b0, 1'b1});
    tbl.push_back('{"sub_zero", C_SUB,  32'h5,         32'h5,          32'h0,         1'b1, 1'b0});
    tbl.push_back('{"slt",      C_SLT,  32'hFFFF_FFFF, 32'h1,          32'h1,         1'b0, 1'b0});
    tbl.push_back('{"sltu",     C_SLTU, 32'hFFFF_FFFF, 32'h1,          32'h0,         1'b1, 1'b0});
    tbl.push_back('{"sra",      C_SRA,  32'h4,         32'h8000_0000,  32'hF800_0000, 1'b0, 1'b0});
    tbl.push_back('{"sll",      C_SLL,  32'h4,         32'h1,          32'h10,        1'b0, 1'b0});
    tbl.push_back('{"srl",      C_SRL,  32'h1F,        32'h8000_0000,  32'h1,         1'b0, 1'b0});
    tbl.push_back('{"and",      C_AND,  32'hF0F0_00FF, 32'h0FF0_0F0F,  32'h00F0_000F, 1'b0, 1'b0});
    tbl.push_back('{"or",       C_OR,   32'hF0F0_00FF, 32'h0FF0_0F0F,  32'hFFF0_0FFF, 1'b0, 1'b0});
    tbl.push_back('{"nor",      C_NOR,  32'hF0F0_00FF, 32'h0FF0_0F0F,  32'h000F_F000, 1'b0, 1'b0});
    tbl.push_back('{"xor",      C_XOR,  32'hF0F0_00FF, 32'h0FF0_0F0F,  32'hFF00_0FF0, 1'b0, 1'b0});
    tbl.push_back('{"sub_ovf",  C_SUB,  32'h8000_0000, 32'h1,          32'h7FFF_FFFF, 1'b0, 1'b1});
    tbl.push_back('{"sub_ovf2", C_SUB,  32'h0,         32'h8000_0000,  32'h8000_0000, 1'b0, 1'b1});
    tbl.push_back('{"add_wrap", C_ADD,  32'hFFFF_FFFF, 32'h1,          32'h0,         1'b1, 1'b0});
    tbl.push_back('{"bad_ctl",  4'b1111, 32'h1234,     32'h5678,       32'h0,         1'b1, 1'b0});

    foreach (tbl[i]) run_simple(tbl[i].nm, tbl[i].c, tbl[i].x, tbl[i].y, tbl[i].eo, tbl[i].ez, tbl[i].ev);

    for (int i = 0; i < 60; i++) begin
      rc = 4'($urandom_range(0, 15));
`ifdef ALU_MULDIV_EN
      if (rc == C_MULT || rc == C_MULTU || rc == C_DIV || rc == C_DIVU) rc = C_XOR;
`endif
      rx = $urandom;
      ry = (i % 4 == 0) ? rx : $urandom;
      model_simple(rc, rx, ry, mo, mv);
      run_simple("rand_simple", rc, rx, ry, mo, (mo == '0), mv);
    end

`ifdef ALU_MULDIV_EN
    run_md("mult",      C_MULT,  32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    run_md("multu",     C_MULTU, 32'hFFFF_FFFD, 32'd5, 32'h4,         32'hFFFF_FFF1, 1'b0);
    run_simple("and_after_md", C_AND, 32'hFF, 32'h0F, 32'h0F, 1'b0, 1'b0);
    run_md("divu",      C_DIVU,  32'd100,       32'd7, 32'd2,         32'd14,        1'b0);
    run_md("div_neg",   C_DIV,   32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_md("div_zero",  C_DIV,   32'd5,         32'd0, 32'd5,         32'hFFFF_FFFF, 1'b0);
    run_md("mult_intr", C_MULT,  32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b1);

    // start held through the done cycle: the next op must be taken at the done edge
    begin
      int n;
      bit bok;
      @(negedge clk);
      start = 1'b1; ctl = C_MULT; a = 32'd6; b = 32'hFFFF_FFF9;
      @(posedge clk);
      #1;
      wait_done(n, bok);
      chk("b2b first latency", n, W + 1);
      chk("b2b first hi", hi, 32'hFFFF_FFFF);
      chk("b2b first lo", lo, 32'hFFFF_FFD6);
      ctl = C_DIVU; a = 32'd100; b = 32'd7;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("b2b accepted busy", busy, 1);
      wait_done(n, bok);
      chk("b2b second latency", n, W + 1);
      chk("b2b second busy", bok, 1);
      chk("b2b second hi", hi, 32'd2);
      chk("b2b second lo", lo, 32'd14);
      exp_hi = 32'd2;
      exp_lo = 32'd14;
    end

    for (int i = 0; i < 16; i++) begin
      case (i % 4)
        0: rc = C_MULT;
        1: rc = C_MULTU;
        2: rc = C_DIV;
        default: rc = C_DIVU;
      endcase
      rx = $urandom;
      case (i % 3)
        0: ry = $urandom;
        1: ry = 32'($signed(5'($urandom_range(0, 31))));
        default: ry = (i < 8) ? 32'd0 : 32'hFFFF_FFFF;
      endcase
      model_md(rc, rx, ry, mh, ml);
      run_md("rand_md", rc, rx, ry, mh, ml, 1'b0);
    end

    // asynchronous reset in the middle of a divide
    issue(C_DIV, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst busy", busy, 0);
    chk("mid_rst hi", hi, 0);
    chk("mid_rst lo", lo, 0);
    chk("mid_rst done", done, 0);
    chk("mid_rst z", z, 1);
    exp_out = '0; exp_z = 1'b1; exp_ovf = 1'b0; exp_hi = '0; exp_lo = '0;
    @(negedge clk);
    rst_n = 1'b1;
    run_md("post_rst_divu", C_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
`else
    run_simple("mult_off",  C_MULT,  32'hFFFF_FFFD, 32'd5, 32'h0, 1'b1, 1'b0);
    run_simple("multu_off", C_MULTU, 32'hFFFF_FFFD, 32'd5, 32'h0, 1'b1, 1'b0);
    run_simple("divu_off",  C_DIVU,  32'd100,       32'd7, 32'h0, 1'b1, 1'b0);
    run_simple("div_off",   C_DIV,   32'hFFFF_FFF9, 32'd2, 32'h0, 1'b1, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
Parametrised multi-cycle successor to the single-cycle datapath ALU. It keeps the existing 4-bit ctl encoding and adds shifts, unsigned compare, overflow detection, and iterative MIPS mult/multu/div/divu with HI/LO result registers. It sits in the EX stage. A start/busy/done handshake lets the pipeline stall on long operations.

Parameters:
WIDTH, 32, operand/result width (≥8, power of 2)
SHW, $clog2(WIDTH), shift-amount width (derived; not overridden)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request; accepted only when busy=0
ctl  in  4  operation code, sampled with start
a  in  WIDTH  operand A (shift amount = a[SHW-1:0])
b  in  WIDTH  operand B (value shifted)
busy  out  1  operation in flight
done  out  1  one-cycle pulse: out/hi/lo/z/ovf valid
out  out  WIDTH  result of non-muldiv ops
z  out  1  out == 0, registered with out
ovf  out  1  signed overflow for add/sub; 0 for all other ops
hi  out  WIDTH  HI register (product high / remainder)
lo  out  WIDTH  LO register (product low / quotient)

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy=0, done=0, out=0, z=1, ovf=0, hi=0, lo=0. Deassertion is synchronous to clk.
- ctl codes:
  - 0010 add; 0110 sub; 0000 and; 0001 or; 1100 nor; 1101 xor
  - 0111 slt (signed); 1000 sltu (unsigned)
  - 0011 sll b<<a; 0100 srl; 0101 sra
  - 1001 multu; 1010 mult; 1011 divu; 1110 div
  - others: out=0
- Acceptance: start && !busy at edge E captures ctl/a/b.
- Simple ops: out/z/ovf update at E+1 with done=1 for that cycle; busy never rises; hi/lo unchanged.
- Mul/div ops:
  - busy=1 from E+1 until done.
  - done pulses at E+WIDTH+2: one load, WIDTH iterations, one sign fixup.
  - out/z/ovf unchanged.
- FSM transitions:
  - IDLE→MUL or DIV on accepted mul/div.
  - MUL→FIX and DIV→FIX when the iteration count reaches WIDTH.
  - FIX→IDLE.
  - done is asserted in the FIX→IDLE transition cycle.
- Iteration counter is SHW+1 bits and counts 0..WIDTH-1.
- mult: 2·WIDTH-bit signed product; {hi,lo}=product.
- div (signed): quotient truncates toward zero; remainder takes the sign of the dividend. Computed by magnitudes, then fixup in FIX.
- Divide by zero: lo = all ones, hi = a (unsigned and signed alike). No exception.
- start while busy=1: ignored, no queueing. Requester must hold start until busy=0.
- start in the same cycle done pulses: done implies busy=0 in that cycle, so start is accepted (back-to-back).
- Reset mid-operation: aborts immediately; hi/lo return to 0.
- ovf for add: sign(a)==sign(b) and sign(out)!=sign(a). For sub: sign(a)!=sign(b) and sign(out)!=sign(a).

Optional Feature:
Macro ALU_MULDIV_EN.
- Defined: mult/multu/div/divu, hi/lo, and the MUL/DIV/FIX states exist as described.
- Undefined:
  - Codes 1001/1010/1011/1110 behave as the default code: out=0, done at E+1.
  - busy is tied 0; hi/lo are tied 0.
  - No iteration logic is synthesised.

Decomposition:
- Package alu_pkg:
  - ctl localparams: ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_NOR, ALU_XOR, ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_MULTU, ALU_MULT, ALU_DIVU, ALU_DIV
  - FSM state typedef: IDLE, MUL, DIV, FIX
  - function is_muldiv(ctl)
- Sub-module alu_mdu (shared shift-add/restoring-subtract iterator, WIDTH param, instantiated only under ALU_MULDIV_EN).
- Combinational ops stay in alu_mc.

Test Plan:
- WIDTH=32, add a=7FFFFFFF b=1 → out=80000000, ovf=1, z=0, done at E+1. Then sub a=5 b=5 → out=0, z=1, ovf=0.
- slt/sltu with a=FFFFFFFF, b=1 → slt out=1, sltu out=0. sra a=4, b=80000000 → out=F8000000.
- mult a=FFFFFFFD (-3), b=5 → hi=FFFFFFFF, lo=FFFFFFF1. busy for cycles E+1..E+33, done pulse at E+34. multu same operands → hi=4, lo=FFFFFFF1.
- divu 100/7 → lo=14, hi=2. div -7/2 → lo=FFFFFFFD, hi=FFFFFFFF. div 5/0 → lo=FFFFFFFF, hi=5.
- start pulsed with a different op at E+5 during a mult → ignored, results unchanged. start held through the done cycle → next op accepted at the done edge.
- rst_n low at E+10 of a div → busy=0, hi=lo=0 immediately (asynchronous). Next start after reset completes normally. Rebuild without ALU_MULDIV_EN → mult returns out=0, done at E+1.
